cbd_sampler_stream: RTL and testbench
=====================================

Name: cbd_sampler_stream

Overview:
- Centered-binomial sampler stage sitting directly downstream of the SHAKE256 PRF.
- Consumes the PRF byte stream as 64-bit little-endian words.
- Emits the 256 coefficients of one polynomial, each mapped into [0, Q), one per cycle over a valid/ready handshake.
- Feeds the polynomial store / NTT input for the s, e, e1, e2 and r vectors during keygen and encap.

Parameters:
- Q, 3329: ML-KEM modulus; coefficients are emitted reduced mod Q.
- N, 256: coefficients per polynomial.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- run_i  in  1  start pulse; eta_i sampled on the same cycle
- eta_i  in  1  0: eta=2, 1: eta=3
- din_valid_i  in  1  PRF word valid
- din_i  in  64  PRF word; byte 0 = din_i[7:0]; bits used LSB-first
- din_ready_o  out  1  sampler accepts din_i this cycle
- coef_valid_o  out  1  coefficient available
- coef_o  out  12  coefficient in [0, Q)
- coef_idx_o  out  8  index 0..255 of coef_o
- coef_ready_i  in  1  downstream accepts coefficient
- busy_o  out  1  high from the cycle after run_i until done_o
- done_o  out  1  one-cycle pulse after the last coefficient is accepted

Behaviour:
- Reset: state IDLE; bit buffer cleared; bit count = 0; word and coefficient counters = 0. All outputs 0.
- States:
  - IDLE -> RUN on run_i. Latch eta (E = 2 or 3); clear counters.
  - RUN -> DONE on the handshake of coefficient 255.
  - DONE -> IDLE after 1 cycle. done_o = 1 only in DONE.
- run_i in RUN or DONE is ignored.
- Bit buffer:
  - 128-bit shift register plus a bit count 0..128.
  - Incoming words are appended above the current valid bits.
  - The coefficient is taken from buffer bits [2E-1:0].
- Input side:
  - din_ready_o = RUN & (words_rcvd < W) & (count <= 64), where W = 16 for eta=2 and 24 for eta=3 (1024 and 1536 bits).
  - An accept (din_valid_i & din_ready_o) increments words_rcvd.
  - Words presented after W words are never accepted.
- Output side:
  - coef_valid_o = RUN & (count >= 2E). It is a function of registered state only.
  - Once asserted, coef_valid_o, coef_o and coef_idx_o hold until coef_ready_i.
- Coefficient arithmetic:
  - x = popcount(buf[E-1:0]); y = popcount(buf[2E-1:E]); d = x - y, with d in [-E, E].
  - coef_o = d when d >= 0, else Q + d. Examples: -2 -> 3327, -3 -> 3326.
- Handshake (coef_valid_o & coef_ready_i): shift the buffer right by 2E, count -= 2E, coef_idx increments.
- Simultaneous input accept and coefficient handshake in one cycle: count <- count + 64 - 2E. The appended word lands above the already-shifted bits.
- Latency:
  - First coef_valid_o is the cycle after the first word is accepted.
  - With din_valid_i and coef_ready_i held high, the sampler sustains 1 coefficient per cycle.
  - Total sequence for N coefficients: run_i, then 256 coefficient cycles, then done_o. No input stall once the buffer is primed.
- End of polynomial: count = 0 and words_rcvd = W exactly on the 256th handshake, since 1024 and 1536 bits are multiples of 4 and 6. No residual bits remain.
- rst_i mid-operation: aborts immediately and returns to reset values. Partial data is discarded and done_o is not pulsed.
- coef_ready_i low in RUN: output stalls; input continues only while count <= 64. No bits are lost or duplicated.
- din_valid_i low: output drains the buffer until count < 2E, then coef_valid_o drops.

Test Plan:
- eta=2, 16 words of 64'h0, coef_ready_i=1 -> 256 coefficients all 0, idx 0..255 in order; done_o one cycle after idx 255; din_ready_o low after 16 words.
- eta=2, words 64'h3C3C3C3C3C3C3C3C (nibbles 0xC, 0x3 alternating, low nibble first) -> coefficient stream 3327, 2, 3327, 2, ... for all 256.
- eta=3, 24 words of 64'hFFFF_FFFF_FFFF_FFFF -> 256 coefficients of 0, exactly 24 words accepted. Second run: first 6-bit groups 0b000111 then 0b111000 -> coefficients 3, 3326.
- eta=3, random words with random din_valid_i and coef_ready_i gaps -> matches reference model CBD(eta=3). No word accepted while count > 64; outputs stable during stalls.
- rst_i asserted after 100 coefficients, then a new run with eta=2 -> no done_o for the aborted run; new run restarts at idx 0 with correct values.
- run_i pulsed again at idx 50 -> ignored; the stream continues to idx 255 and exactly one done_o is produced.

Source files
------------

// File: rtl/cbd_sampler_stream_if.sv
// Handshake bundle between the PRF-fed CBD sampler and its neighbours.
// slave: the sampler itself; master: the side driving run/PRF words/ready.
interface cbd_sampler_stream_if;
    logic        run_i;
    logic        eta_i;
    logic        din_valid_i;
    logic [63:0] din_i;
    logic        din_ready_o;
    logic        coef_valid_o;
    logic [11:0] coef_o;
    logic [7:0]  coef_idx_o;
    logic        coef_ready_i;
    logic        busy_o;
    logic        done_o;

    modport slave (
        input  run_i, eta_i, din_valid_i, din_i, coef_ready_i,
        output din_ready_o, coef_valid_o, coef_o, coef_idx_o, busy_o, done_o
    );

    modport master (
        output run_i, eta_i, din_valid_i, din_i, coef_ready_i,
        input  din_ready_o, coef_valid_o, coef_o, coef_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/cbd_sampler_stream.sv
// Centered-binomial sampler: turns a 64-bit LE PRF word stream into the
// N coefficients of one polynomial (eta = 2 or 3), reduced into [0, Q).
// A 128-bit LSB-first bit buffer decouples word arrival from coefficient
// consumption; new words land directly above the bits still valid.
module cbd_sampler_stream #(
    parameter int Q = 3329,
    parameter int N = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cbd_sampler_stream_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q;
    logic [127:0] buf_q;
    logic [7:0]   cnt_q;      // valid bits in buf_q, 0..128
    logic [4:0]   words_q;    // words accepted this polynomial
    logic [7:0]   idx_q;      // index of the coefficient currently offered
    logic         eta3_q;
    logic         busy_q;
    logic         done_q;

    logic [7:0]   step;       // 2*eta bits per coefficient
    logic [4:0]   wmax;       // words per polynomial
    logic         in_ready;
    logic         out_valid;
    logic         accept;
    logic         take;
    logic [1:0]   x;
    logic [1:0]   y;
    logic [11:0]  coef;
    logic [127:0] shifted;
    logic [7:0]   base;
    logic [127:0] buf_next;
    logic [7:0]   cnt_next;

    // Handshake qualifiers depend only on registered state, so coef_valid
    // never combinationally follows the downstream ready.
    always_comb begin
        step      = eta3_q ? 8'd6 : 8'd4;
        wmax      = eta3_q ? 5'd24 : 5'd16;
        in_ready  = (state_q == RUN) && (words_q < wmax) && (cnt_q <= 8'd64);
        out_valid = (state_q == RUN) && (cnt_q >= step);
        accept    = in_ready & bus.din_valid_i;
        take      = out_valid & bus.coef_ready_i;
    end

    // Coefficient from the lowest 2*eta buffer bits: popcount difference,
    // negative results folded up by Q.
    always_comb begin
        x = 2'(buf_q[0]) + 2'(buf_q[1]) + 2'(eta3_q & buf_q[2]);
        if (eta3_q)
            y = 2'(buf_q[3]) + 2'(buf_q[4]) + 2'(buf_q[5]);
        else
            y = 2'(buf_q[2]) + 2'(buf_q[3]);
        if (x >= y)
            coef = 12'(x - y);
        else
            coef = 12'(Q) - 12'(y - x);
    end

    // Next buffer contents: drop the consumed group first, then append the
    // incoming word right above whatever bits survive.
    always_comb begin
        shifted  = buf_q;
        base     = cnt_q;
        if (take) begin
            shifted = eta3_q ? (buf_q >> 6) : (buf_q >> 4);
            base    = cnt_q - step;
        end
        buf_next = shifted;
        cnt_next = base;
        if (accept) begin
            buf_next = shifted | ({64'b0, bus.din_i} << base);
            cnt_next = base + 8'd64;
        end
    end

    // Control FSM plus datapath registers; busy/done are registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            eta3_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.run_i) begin
                        state_q <= RUN;
                        eta3_q  <= bus.eta_i;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        words_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    buf_q <= buf_next;
                    cnt_q <= cnt_next;
                    if (accept)
                        words_q <= words_q + 5'd1;
                    if (take) begin
                        idx_q <= idx_q + 8'd1;
                        if (idx_q == 8'(N - 1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.din_ready_o  = in_ready;
    assign bus.coef_valid_o = out_valid;
    assign bus.coef_o       = coef;
    assign bus.coef_idx_o   = idx_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;

endmodule

// File: tb/tb_cbd_sampler_stream.sv
// Randomized bench for cbd_sampler_stream against a bit-stream reference:
// every accepted word is stored, coefficient k is recomputed from the
// absolute bit positions 2*E*k .. 2*E*k+2E-1 of the accepted stream.
module tb_cbd_sampler_stream;

    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cbd_sampler_stream_if bus();

    cbd_sampler_stream dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    bit          m_run;
    bit          m_done;
    int          m_e;
    int          m_w;
    int          m_acc;
    int          m_hs;
    logic [63:0] m_words [24];
    int          n_done;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic int ref_bit(input int i);
        logic [63:0] w;
        w = m_words[i / 64];
        return int'(w[i % 64]);
    endfunction

    function automatic int ref_coef(input int k);
        int x = 0;
        int y = 0;
        int d;
        for (int j = 0; j < m_e; j++) begin
            x += ref_bit(2 * m_e * k + j);
            y += ref_bit(2 * m_e * k + m_e + j);
        end
        d = x - y;
        return (d < 0) ? Q + d : d;
    endfunction

    function automatic logic [63:0] gen_word(input int mode, input int widx);
        case (mode)
            0:       return 64'h0;
            1:       return 64'h3C3C_3C3C_3C3C_3C3C;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            4:       return (widx == 0) ? 64'h0000_0000_0000_0E07 : {$urandom, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One clock: check DUT outputs against the model, drive inputs,
    // then advance the model by what the coming edge will do.
    task automatic tick(input bit run, input bit eta, input bit dv,
                        input logic [63:0] w, input bit cr);
        int  cnt;
        bit  exp_rdy, exp_vld, acc, hs, was_run, was_done;
        @(negedge clk);
        cnt     = m_acc * 64 - m_hs * 2 * m_e;
        exp_rdy = m_run && (m_acc < m_w) && (cnt <= 64);
        exp_vld = m_run && (cnt >= 2 * m_e);
        chk("din_ready", int'(bus.din_ready_o), int'(exp_rdy));
        chk("coef_valid", int'(bus.coef_valid_o), int'(exp_vld));
        if (exp_vld) begin
            chk("coef", int'(bus.coef_o), ref_coef(m_hs));
            chk("coef_idx", int'(bus.coef_idx_o), m_hs);
        end
        chk("busy", int'(bus.busy_o), int'(m_run || m_done));
        chk("done", int'(bus.done_o), int'(m_done));
        if (bus.done_o) n_done++;

        bus.run_i        = run;
        bus.eta_i        = eta;
        bus.din_valid_i  = dv;
        bus.din_i        = w;
        bus.coef_ready_i = cr;

        acc      = dv && exp_rdy;
        hs       = cr && exp_vld;
        was_run  = m_run;
        was_done = m_done;
        if (acc) begin
            m_words[m_acc] = w;
            m_acc++;
        end
        if (hs) m_hs++;
        if (was_done) m_done = 0;
        if (was_run && hs && m_hs == 256) begin
            m_run  = 0;
            m_done = 1;
        end
        if (!was_run && !was_done && run) begin
            m_run = 1;
            m_e   = eta ? 3 : 2;
            m_w   = eta ? 24 : 16;
            m_acc = 0;
            m_hs  = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus.run_i        = 1'b0;
        bus.eta_i        = 1'b0;
        bus.din_valid_i  = 1'b0;
        bus.din_i        = '0;
        bus.coef_ready_i = 1'b0;
        m_run  = 0;
        m_done = 0;
        m_e    = 0;
        m_w    = 0;
        m_acc  = 0;
        m_hs   = 0;
        repeat (2) @(negedge clk);
        chk("rst_coef", int'(bus.coef_o), 0);
        chk("rst_idx", int'(bus.coef_idx_o), 0);
        chk("rst_valid", int'(bus.coef_valid_o), 0);
        chk("rst_ready", int'(bus.din_ready_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        rst = 1'b0;
    endtask

    // Run one polynomial. pv/pc: percent of cycles with din_valid/coef_ready.
    // abort_at: reset once that many coefficients were taken (-1: never).
    // rerun_at: pulse run (with the other eta) at that index (-1: never).
    task automatic do_poly(input bit eta, input int mode, input int pv, input int pc,
                           input int abort_at, input int rerun_at);
        int  cyc;
        bit  dv, cr, rr, aborted;
        n_done  = 0;
        aborted = 0;
        tick(1'b1, eta, 1'b0, '0, 1'b0);
        cyc = 0;
        while (!(m_hs == 256 && !m_run && !m_done) && cyc < 6000) begin
            if (abort_at >= 0 && m_hs == abort_at) begin
                do_reset();
                aborted = 1;
                break;
            end
            dv = ($urandom_range(0, 99) < pv);
            cr = ($urandom_range(0, 99) < pc);
            rr = (rerun_at >= 0 && m_hs == rerun_at);
            tick(rr, rr ? !eta : eta, dv, gen_word(mode, m_acc), cr);
            cyc++;
        end
        if (cyc >= 6000) chk("timeout", 0, 1);
        chk(aborted ? "abort_no_done" : "done_count", n_done, aborted ? 0 : 1);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        bus.run_i        = 1'b0;
        bus.eta_i        = 1'b0;
        bus.din_valid_i  = 1'b0;
        bus.din_i        = '0;
        bus.coef_ready_i = 1'b0;
        do_reset();
        do_poly(1'b0, 0, 100, 100, -1, -1);   // eta=2, all-zero words
        do_poly(1'b0, 1, 100, 100, -1, -1);   // eta=2, 0x3C pattern -> 3327, 2, ...
        do_poly(1'b1, 2, 100, 100, -1, -1);   // eta=3, all-ones words
        do_poly(1'b1, 4, 100, 100, -1, -1);   // eta=3, leading 3, 3326
        do_poly(1'b1, 3, 60, 70, -1, -1);     // eta=3, random with gaps
        do_poly(1'b0, 3, 100, 100, 100, -1);  // aborted by reset at idx 100
        do_poly(1'b0, 3, 80, 80, -1, -1);     // fresh eta=2 run after abort
        do_poly(1'b0, 3, 100, 100, -1, 50);   // run re-pulsed at idx 50
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
